sd_data_master_ctrl: RTL

//  Sequences multi-block SD data transfers through the serial data host (sd_data_serial_host).

---
 rtl/sd_data_master_ctrl_pkg.sv | 37 +++
 rtl/sd_timeout_cnt.sv | 47 ++++
 rtl/sd_data_master_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/sd_data_master_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : sd_data_master_ctrl_pkg
// Purpose: Shared definitions for the SD data master controller: one-hot
//          state encoding, start_dat command codes, status bit indices and
//          a helper that maps transfer direction to its start code.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package sd_data_master_ctrl_pkg;

  typedef enum logic [6:0] {
    ST_IDLE      = 7'b0000001,
    ST_WAIT_FIFO = 7'b0000010,
    ST_START     = 7'b0000100,
    ST_XFER      = 7'b0001000,
    ST_ACK       = 7'b0010000,
    ST_STOP      = 7'b0100000,
    ST_DONE      = 7'b1000000
  } state_e;

  localparam logic [1:0] START_DAT_NONE  = 2'b00;
  localparam logic [1:0] START_DAT_WRITE = 2'b01;
  localparam logic [1:0] START_DAT_READ  = 2'b10;
  localparam logic [1:0] START_DAT_STOP  = 2'b11;

  localparam int STATUS_CRC_ERR = 0;
  localparam int STATUS_TIMEOUT = 1;
  localparam int STATUS_ABORTED = 2;

  // dir: 0 = write (card <- host), 1 = read
  function automatic logic [1:0] start_code(input logic dir);
    return dir ? START_DAT_READ : START_DAT_WRITE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module : sd_timeout_cnt
// Purpose: Per-block down-counter. Loaded with a cycle budget; a load value
//          of zero disables it. expire_o flags the enabled cycle in which the
//          count reaches zero, so the owner can react on that same edge.
// Ports  : clk_i      clock
//          rst_ni     asynchronous active-low reset
//          load_i     load load_val_i (overrides enable)
//          load_val_i timeout budget in cycles, 0 = disabled
//          en_i       count this cycle
//          expire_o   count reaches zero at the end of this cycle
// Rev    : 1.0  initial release
// ============================================================================
module sd_timeout_cnt #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [TIMEOUT_W-1:0] load_val_i,
  input  logic                 en_i,
  output logic                 expire_o
);

  logic [TIMEOUT_W-1:0] cnt_q;
  logic                 armed_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else if (load_i) begin
      cnt_q   <= load_val_i;
      armed_q <= (load_val_i != '0);
    end else if (en_i && armed_q) begin
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == TIMEOUT_W'(1)) begin
        armed_q <= 1'b0;
      end
    end
  end

  assign expire_o = armed_q && en_i && (cnt_q == TIMEOUT_W'(1));

endmodule
`default_nettype wire

// File: rtl/sd_data_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module : sd_data_master_ctrl
// Purpose: Sequences multi-block SD data transfers through the serial data
//          host. Accepts one command, gates each block on FIFO readiness,
//          drives start_dat/ack_transfer per block, checks per-block CRC,
//          enforces per-block timeout and abort, and reports one completion
//          pulse with status.
// Ports  : sd_clk_i / rst_ni            clock, async active-low reset
//          cmd_valid_i / cmd_ready_o    command handshake (ready only in IDLE)
//          cmd_dir_i, cmd_blk_cnt_i, cmd_timeout_i   command fields
//          abort_i                      level abort request
//          tx_fifo_ready_i / rx_fifo_ready_i         block-level FIFO readiness
//          start_dat_o, ack_transfer_o  to serial host
//          busy_n_i, transm_complete_i, crc_ok_i     from serial host
//          xfer_busy_o, done_o, status_o, blk_done_cnt_o  status to register side
// Rev    : 1.0  initial release
// ============================================================================
module sd_data_master_ctrl
  import sd_data_master_ctrl_pkg::*;
#(
  parameter int BLKCNT_W  = 8,
  parameter int TIMEOUT_W = 16,
  parameter int STOP_CYC  = 64
) (
  input  logic                 sd_clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_dir_i,
  input  logic [BLKCNT_W-1:0]  cmd_blk_cnt_i,
  input  logic [TIMEOUT_W-1:0] cmd_timeout_i,
  input  logic                 abort_i,
  input  logic                 tx_fifo_ready_i,
  input  logic                 rx_fifo_ready_i,
  output logic [1:0]           start_dat_o,
  output logic                 ack_transfer_o,
  input  logic                 busy_n_i,
  input  logic                 transm_complete_i,
  input  logic                 crc_ok_i,
  output logic                 xfer_busy_o,
  output logic                 done_o,
  output logic [2:0]           status_o,
  output logic [BLKCNT_W-1:0]  blk_done_cnt_o
);

  localparam int                STOP_W    = (STOP_CYC > 2) ? $clog2(STOP_CYC) : 1;
  localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_CYC - 1);

  state_e               state_q, state_d;
  logic                 dir_q, dir_d;
  logic [BLKCNT_W-1:0]  remain_q, remain_d;
  logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
  logic [1:0]           start_dat_q, start_dat_d;
  logic                 ack_q, ack_d;
  logic                 done_q, done_d;
  logic [2:0]           status_q, status_d;
  logic [BLKCNT_W-1:0]  blk_cnt_q, blk_cnt_d;
  logic                 busy_seen_q, busy_seen_d;
  logic [STOP_W-1:0]    stop_cnt_q, stop_cnt_d;

  logic                 to_load;
  logic                 to_en;
  logic                 to_expire;
  logic                 fifo_ok;

  assign fifo_ok = dir_q ? rx_fifo_ready_i : tx_fifo_ready_i;
  assign to_en   = (state_q == ST_START) || (state_q == ST_XFER);

  sd_timeout_cnt #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timeout (
    .clk_i      (sd_clk_i),
    .rst_ni     (rst_ni),
    .load_i     (to_load),
    .load_val_i (timeout_q),
    .en_i       (to_en),
    .expire_o   (to_expire)
  );

  always_ff @(posedge sd_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      dir_q       <= 1'b0;
      remain_q    <= '0;
      timeout_q   <= '0;
      start_dat_q <= START_DAT_NONE;
      ack_q       <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= '0;
      blk_cnt_q   <= '0;
      busy_seen_q <= 1'b0;
      stop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      remain_q    <= remain_d;
      timeout_q   <= timeout_d;
      start_dat_q <= start_dat_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      status_q    <= status_d;
      blk_cnt_q   <= blk_cnt_d;
      busy_seen_q <= busy_seen_d;
      stop_cnt_q  <= stop_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    remain_d    = remain_q;
    timeout_d   = timeout_q;
    start_dat_d = start_dat_q;
    ack_d       = ack_q;
    done_d      = 1'b0;
    status_d    = status_q;
    blk_cnt_d   = blk_cnt_q;
    busy_seen_d = busy_seen_q;
    stop_cnt_d  = stop_cnt_q;
    to_load     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          dir_d     = cmd_dir_i;
          remain_d  = cmd_blk_cnt_i;
          timeout_d = cmd_timeout_i;
          status_d  = '0;
          blk_cnt_d = '0;
          state_d   = (cmd_blk_cnt_i == '0) ? ST_DONE : ST_WAIT_FIFO;
        end
      end

      ST_WAIT_FIFO: begin
        // No block is active yet, so an abort needs no stop handshake.
        if (abort_i) begin
          status_d[STATUS_ABORTED] = 1'b1;
          state_d                  = ST_DONE;
        end else if (fifo_ok) begin
          start_dat_d = start_code(dir_q);
          to_load     = 1'b1;
          busy_seen_d = 1'b0;
          state_d     = ST_START;
        end
      end

      ST_START: begin
        if (abort_i || to_expire) begin
          if (abort_i) status_d[STATUS_ABORTED] = 1'b1;
          else         status_d[STATUS_TIMEOUT] = 1'b1;
          start_dat_d = START_DAT_STOP;
          ack_d       = 1'b1;
          stop_cnt_d  = '0;
          state_d     = ST_STOP;
        end else if (!busy_n_i) begin
          start_dat_d = START_DAT_NONE;
          busy_seen_d = 1'b1;
          state_d     = ST_XFER;
        end
      end

      ST_XFER: begin
        if (!busy_n_i) busy_seen_d = 1'b1;
        // Priority: abort > completion > timeout. A stale transm_complete
        // from the previous block is ignored until busy_n has dropped.
        if (abort_i) begin
          status_d[STATUS_ABORTED] = 1'b1;
          start_dat_d = START_DAT_STOP;
          ack_d       = 1'b1;
          stop_cnt_d  = '0;
          state_d     = ST_STOP;
        end else if (transm_complete_i && busy_seen_q) begin
          if (!crc_ok_i) status_d[STATUS_CRC_ERR] = 1'b1;
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end else if (to_expire) begin
          status_d[STATUS_TIMEOUT] = 1'b1;
          start_dat_d = START_DAT_STOP;
          ack_d       = 1'b1;
          stop_cnt_d  = '0;
          state_d     = ST_STOP;
        end
      end

      ST_ACK: begin
        if (busy_n_i) begin
          ack_d = 1'b0;
          if (!status_q[STATUS_CRC_ERR]) begin
            blk_cnt_d = blk_cnt_q + 1'b1;
            remain_d  = (remain_q != '0) ? remain_q - 1'b1 : '0;
          end
          if (status_q[STATUS_CRC_ERR] || (remain_q <= BLKCNT_W'(1))) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT_FIFO;
          end
        end
      end

      ST_STOP: begin
        if (busy_n_i || (stop_cnt_q == STOP_LAST)) begin
          start_dat_d = START_DAT_NONE;
          ack_d       = 1'b0;
          state_d     = ST_DONE;
        end else begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        start_dat_d = START_DAT_NONE;
        ack_d       = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  assign cmd_ready_o    = (state_q == ST_IDLE);
  assign xfer_busy_o    = (state_q != ST_IDLE);
  assign start_dat_o    = start_dat_q;
  assign ack_transfer_o = ack_q;
  assign done_o         = done_q;
  assign status_o       = status_q;
  assign blk_done_cnt_o = blk_cnt_q;

endmodule
`default_nettype wire
